wb_source_pipe: RTL and testbench
=================================

// Module: wb_source_pipe
// PURPOSE
//  Parametrised register-writeback source selector with a registered output stage.
//  Picks one of NSRC data sources (ALU result, immediate, memory load, I/O) per
//  instruction and holds the result in a valid/ready pipeline stage until the
//  register file accepts it. Sits between execute/memory and the register-file
//  write port; replaces the plain 2:1 ALU/immediate writeback select.
// PARAMETERS
//  BITS    8   data width of every source and of wb_data
//  NSRC    4   number of selectable sources (>=2)
//  SEL_W   $clog2(NSRC)  width of src_sel (derived, do not override)
//  ADDR_W  3   destination register address width
// PORTS
//  clk       in   1            system clock, rising edge
//  rst       in   1            asynchronous reset, active-high
//  in_valid  in   1            upstream request valid
//  in_ready  out  1            stage can accept a request this cycle
//  src_sel   in   SEL_W        source index (0=ALU, 1=imm, 2=load, 3=I/O by convention)
//  src_bus   in   NSRC*BITS    flattened sources; source k = src_bus[k*BITS +: BITS]
//  rd_addr   in   ADDR_W       destination register
//  out_valid out  1            wb_data/wb_addr hold a pending write
//  out_ready in   1            register file accepts the write this cycle
//  wb_data   out  BITS         selected data, registered
//  wb_addr   out  ADDR_W       destination, registered
//  wb_zero   out  1            registered flag: wb_data == 0
//  sel_err   out  1            sticky: an accepted request had src_sel >= NSRC
// BEHAVIOUR
//  - Reset (async, any time incl. mid-transfer): out_valid=0, wb_data=0, wb_addr=0,
//    wb_zero=0, sel_err=0; any pending/skid entry discarded. in_ready=1 after reset.
//  - Accept: in_valid && in_ready at rising edge. Push: out_valid && out_ready.
//  - Latency 1: accepted request visible on wb_* with out_valid=1 on the next cycle.
//  - in_ready = !out_valid || out_ready (combinational) -> full throughput 1/cycle.
//  - Simultaneous push+accept: new entry replaces old in same edge, out_valid stays 1.
//  - Push without accept: out_valid->0; wb_data/wb_addr/wb_zero hold last values.
//  - out_valid=1 && !out_ready: wb_data, wb_addr, wb_zero stable until pushed.
//  - src_sel >= NSRC (only possible when NSRC not a power of 2): selected data = 0,
//    wb_zero=1, entry still delivered; sel_err set the cycle after accept and held
//    until reset.
//  - No arithmetic; data passes bit-exact, width BITS, no sign/zero extension.
//  - Inputs other than in_valid/out_ready are sampled only on an accept edge.
// CONFIGURATION
//  WB_SKID_EN defined: 2-entry stage (output reg + skid reg). in_ready is a pure
//    register output = !skid_full, breaking the out_ready->in_ready comb path.
//    Accept while out_valid && !out_ready fills skid; on next push skid moves to
//    output (order preserved). Latency to out_valid still 1 when output empty.
//    Reset clears skid_full (in_ready=1).
//  WB_SKID_EN undefined: single entry, in_ready combinational as above.
// TESTING
//  1. Reset: assert rst mid-cycle with out_valid=1 -> out_valid=0, wb_data=0x00,
//     sel_err=0, in_ready=1 immediately (no clock).
//  2. Select sweep (NSRC=4): sources 0x11,0x22,0x33,0x44; src_sel 0..3, rd_addr 5,
//     out_ready=1 -> wb_data 0x11,0x22,0x33,0x44 on consecutive cycles, wb_addr=5.
//  3. Backpressure: out_ready=0, accept 0xA5 -> out_valid=1 held, in_ready=0, wb_data
//     stable 0xA5 for 10 cycles; raise out_ready -> one push, next entry accepted.
//  4. Zero/err: NSRC=3, src_sel=3 -> wb_data=0x00, wb_zero=1, sel_err=1 and stays 1
//     after later valid selects until rst.
//  5. Throughput: in_valid=1, out_ready=1 for 16 cycles, random sources -> 16 writes,
//     no bubble, data order matches scoreboard.
//  6. WB_SKID_EN: out_ready=0, send 0x01,0x02 -> in_ready drops after 2nd accept;
//     out_ready=1 -> wb_data 0x01 then 0x02, in_ready=1 again.

Source files
------------

// File: rtl/wb_source_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : wb_source_pipe
//  Description : Register-writeback source selector with a valid/ready output
//                stage. Selects one of NSRC sources per request and holds the
//                result until the register file accepts it.
//                Optional macro WB_SKID_EN adds a skid entry so that in_ready
//                comes straight from a register.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_source_pipe #(
    parameter int BITS   = 8,
    parameter int NSRC   = 4,
    parameter int SEL_W  = $clog2(NSRC),
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       src_sel,
    input  logic [NSRC*BITS-1:0]   src_bus,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BITS-1:0]        wb_data,
    output logic [ADDR_W-1:0]      wb_addr,
    output logic                   wb_zero,
    output logic                   sel_err
);

    // One extra bit so a power-of-two NSRC is representable in the compare.
    localparam logic [SEL_W:0] c_nsrc = NSRC[SEL_W:0];

    logic [BITS-1:0]   w_sel_data;
    logic              w_sel_bad;
    logic              w_sel_zero;
    logic              w_accept;

    logic              r_out_valid;
    logic [BITS-1:0]   r_wb_data;
    logic [ADDR_W-1:0] r_wb_addr;
    logic              r_wb_zero;
    logic              r_sel_err;

    // Source mux: an out-of-range index matches no source and yields zero.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if ({1'b0, src_sel} == k[SEL_W:0]) begin
                w_sel_data = src_bus[k*BITS +: BITS];
            end
        end
        w_sel_bad  = ({1'b0, src_sel} >= c_nsrc);
        w_sel_zero = (w_sel_data == '0);
    end

    // Sticky flag for any accepted request with an illegal source index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_sel_bad) begin
            r_sel_err <= 1'b1;
        end
    end

`ifdef WB_SKID_EN
    logic              r_skid_full;
    logic              r_in_ready;
    logic [BITS-1:0]   r_skid_data;
    logic [ADDR_W-1:0] r_skid_addr;
    logic              r_skid_zero;
    logic              w_out_free;
    logic              w_skid_fill;
    logic              w_skid_full_nxt;

    assign in_ready   = r_in_ready;
    assign w_accept   = in_valid && r_in_ready;
    assign w_out_free = !r_out_valid || out_ready;

    // Skid fills only when the output register is occupied and not draining;
    // it empties into the output register as soon as that register frees up.
    always_comb begin
        w_skid_fill     = !r_skid_full && w_accept && !w_out_free;
        w_skid_full_nxt = r_skid_full;
        if (r_skid_full && w_out_free) begin
            w_skid_full_nxt = 1'b0;
        end else if (w_skid_fill) begin
            w_skid_full_nxt = 1'b1;
        end
    end

    // Output register: skid entry has priority to preserve ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_wb_data   <= '0;
            r_wb_addr   <= '0;
            r_wb_zero   <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_full) begin
                r_out_valid <= 1'b1;
                r_wb_data   <= r_skid_data;
                r_wb_addr   <= r_skid_addr;
                r_wb_zero   <= r_skid_zero;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_wb_data   <= w_sel_data;
                r_wb_addr   <= rd_addr;
                r_wb_zero   <= w_sel_zero;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Skid register plus a registered copy of its emptiness for in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_full <= 1'b0;
            r_in_ready  <= 1'b1;
            r_skid_data <= '0;
            r_skid_addr <= '0;
            r_skid_zero <= 1'b0;
        end else begin
            r_skid_full <= w_skid_full_nxt;
            r_in_ready  <= !w_skid_full_nxt;
            if (w_skid_fill) begin
                r_skid_data <= w_sel_data;
                r_skid_addr <= rd_addr;
                r_skid_zero <= w_sel_zero;
            end
        end
    end
`else
    logic w_push;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_push   = r_out_valid && out_ready;

    // Single-entry stage: an accept overwrites (or refills) the entry, a bare
    // push only drops valid so the data fields keep their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_wb_data   <= '0;
            r_wb_addr   <= '0;
            r_wb_zero   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_wb_data   <= w_sel_data;
            r_wb_addr   <= rd_addr;
            r_wb_zero   <= w_sel_zero;
        end else if (w_push) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign wb_data   = r_wb_data;
    assign wb_addr   = r_wb_addr;
    assign wb_zero   = r_wb_zero;
    assign sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_source_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_source_pipe
//  Description : Directed self-checking bench for wb_source_pipe (NSRC=4 and
//                NSRC=3 instances). Skid behaviour is exercised when the bench
//                is built with WB_SKID_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_source_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // NSRC=4 instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  src_sel = '0;
    logic [31:0] src_bus = '0;
    logic [2:0]  rd_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  wb_data;
    logic [2:0]  wb_addr;
    logic        wb_zero;
    logic        sel_err;

    // NSRC=3 instance
    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [1:0]  src_sel3 = '0;
    logic [23:0] src_bus3 = '0;
    logic [2:0]  rd_addr3 = '0;
    logic        out_valid3;
    logic        out_ready3 = 1'b1;
    logic [7:0]  wb_data3;
    logic [2:0]  wb_addr3;
    logic        wb_zero3;
    logic        sel_err3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_source_pipe #(.BITS(8), .NSRC(4), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .src_sel(src_sel), .src_bus(src_bus), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_addr(wb_addr), .wb_zero(wb_zero), .sel_err(sel_err)
    );

    wb_source_pipe #(.BITS(8), .NSRC(3), .ADDR_W(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .src_sel(src_sel3), .src_bus(src_bus3), .rd_addr(rd_addr3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .wb_data(wb_data3), .wb_addr(wb_addr3), .wb_zero(wb_zero3), .sel_err(sel_err3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || wb_data !== 8'h00 ||
            wb_zero !== 1'b0 || sel_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: rdy=%b vld=%b data=%h zero=%b err=%b, want 1 0 00 0 0",
                     in_ready, out_valid, wb_data, wb_zero, sel_err);
        end
        // load an entry and hold it, then reset asynchronously mid-cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        src_sel   = 2'd0;
        src_bus   = 32'h0000_007E;
        rd_addr   = 3'd6;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || wb_data !== 8'h7E) begin
            n_fail++;
            $display("FAIL reset_pre: vld=%b data=%h, want 1 7e", out_valid, wb_data);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || wb_data !== 8'h00 || wb_addr !== 3'd0 ||
            sel_err !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: vld=%b data=%h addr=%0d err=%b rdy=%b, want 0 00 0 0 1",
                     out_valid, wb_data, wb_addr, sel_err, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_select_sweep();
        logic [7:0] exp_d [4];
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        src_bus   = 32'h4433_2211;
        rd_addr   = 3'd5;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_sel = i[1:0];
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || wb_data !== exp_d[i] || wb_addr !== 3'd5 || wb_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_sel%0d: vld=%b data=%h addr=%0d zero=%b, want 1 %h 5 0",
                         i, out_valid, wb_data, wb_addr, wb_zero, exp_d[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || wb_data !== 8'h44) begin
            n_fail++;
            $display("FAIL sweep_drain: vld=%b data=%h, want 0 44", out_valid, wb_data);
        end
        // zero source flag on the 4-source instance
        src_bus  = 32'h4433_0011;
        src_sel  = 2'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (wb_data !== 8'h00 || wb_zero !== 1'b1 || sel_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_flag: data=%h zero=%b err=%b, want 00 1 0", wb_data, wb_zero, sel_err);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        src_bus   = 32'h0000_5AA5;
        src_sel   = 2'd0;
        rd_addr   = 3'd2;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || wb_data !== 8'hA5 || wb_addr !== 3'd2) begin
                n_fail++;
                $display("FAIL bp_hold%0d: vld=%b data=%h addr=%0d, want 1 a5 2",
                         i, out_valid, wb_data, wb_addr);
            end
`ifndef WB_SKID_EN
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready%0d: in_ready=%b, want 0", i, in_ready);
            end
`endif
            tick();
        end
        // release: push A5 and accept 5A on the same edge
        src_sel   = 2'd1;
        rd_addr   = 3'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: in_ready=%b, want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || wb_data !== 8'h5A || wb_addr !== 3'd3) begin
            n_fail++;
            $display("FAIL bp_next: vld=%b data=%h addr=%0d, want 1 5a 3", out_valid, wb_data, wb_addr);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || wb_data !== 8'h5A || wb_addr !== 3'd3) begin
            n_fail++;
            $display("FAIL bp_drain_hold: vld=%b data=%h addr=%0d, want 0 5a 3", out_valid, wb_data, wb_addr);
        end
    endtask

    task automatic test_sel_err();
        src_bus3   = 24'h33_2211;
        rd_addr3   = 3'd4;
        out_ready3 = 1'b1;
        n_tests++;
        if (sel_err3 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_initial: sel_err=%b, want 0", sel_err3);
        end
        src_sel3  = 2'd3;
        in_valid3 = 1'b1;
        tick();
        n_tests++;
        if (out_valid3 !== 1'b1 || wb_data3 !== 8'h00 || wb_zero3 !== 1'b1 || sel_err3 !== 1'b1) begin
            n_fail++;
            $display("FAIL err_bad_sel: vld=%b data=%h zero=%b err=%b, want 1 00 1 1",
                     out_valid3, wb_data3, wb_zero3, sel_err3);
        end
        src_sel3 = 2'd1;
        tick();
        src_sel3 = 2'd2;
        tick();
        in_valid3 = 1'b0;
        n_tests++;
        if (wb_data3 !== 8'h33 || wb_zero3 !== 1'b0 || sel_err3 !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: data=%h zero=%b err=%b, want 33 0 1", wb_data3, wb_zero3, sel_err3);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (sel_err3 !== 1'b0 || out_valid3 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b vld=%b, want 0 0", sel_err3, out_valid3);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [$];
        logic [7:0] exp_v;
        int writes = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            src_bus = $urandom;
            src_sel = 2'($urandom_range(0, 3));
            rd_addr = 3'(i);
            case (src_sel)
                2'd0: exp_v = src_bus[7:0];
                2'd1: exp_v = src_bus[15:8];
                2'd2: exp_v = src_bus[23:16];
                default: exp_v = src_bus[31:24];
            endcase
            exp_q.push_back(exp_v);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL tput_ready%0d: in_ready=%b, want 1", i, in_ready);
            end
            tick();
            if (out_valid === 1'b1) writes++;
            exp_v = exp_q.pop_front();
            n_tests++;
            if (out_valid !== 1'b1 || wb_data !== exp_v || wb_addr !== 3'(i)) begin
                n_fail++;
                $display("FAIL tput_data%0d: vld=%b data=%h addr=%0d, want 1 %h %0d",
                         i, out_valid, wb_data, wb_addr, exp_v, i);
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (writes != 16) begin
            n_fail++;
            $display("FAIL tput_count: writes=%0d, want 16", writes);
        end
        tick();
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        src_bus   = 32'h0000_0201;
        rd_addr   = 3'd1;
        src_sel   = 2'd0;
        in_valid  = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || wb_data !== 8'h01) begin
            n_fail++;
            $display("FAIL skid_first: vld=%b data=%h, want 1 01", out_valid, wb_data);
        end
        src_sel = 2'd1;
        rd_addr = 3'd2;
`ifdef WB_SKID_EN
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_room: in_ready=%b, want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0 || wb_data !== 8'h01 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_full: rdy=%b data=%h vld=%b, want 0 01 1", in_ready, wb_data, out_valid);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || wb_data !== 8'h02 || wb_addr !== 3'd2 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_second: vld=%b data=%h addr=%0d rdy=%b, want 1 02 2 1",
                     out_valid, wb_data, wb_addr, in_ready);
        end
`else
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_full: in_ready=%b, want 0", in_ready);
        end
        tick();
        n_tests++;
        if (wb_data !== 8'h01 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_blocked: data=%h vld=%b, want 01 1", wb_data, out_valid);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || wb_data !== 8'h02 || wb_addr !== 3'd2) begin
            n_fail++;
            $display("FAIL single_second: vld=%b data=%h addr=%0d, want 1 02 2", out_valid, wb_data, wb_addr);
        end
`endif
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_empty: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        #12;
        @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_select_sweep();
        test_backpressure();
        test_sel_err();
        test_back_to_back();
        test_skid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
